// File: rtl/prover_late_seq_pkg.sv
// Shared types and field helpers for the late-round sum-check sequencer.
// F_NBITS / F_Q default here only when the surrounding build has not defined them.
`ifndef F_NBITS
`define F_NBITS 32
`endif
`ifndef F_Q
`define F_Q 32'hFFFF_FFFB
`endif

package prover_late_seq_pkg;

    localparam int unsigned F_NBITS = `F_NBITS;
    localparam logic [F_NBITS-1:0] F_Q = F_NBITS'(`F_Q);

    typedef logic [F_NBITS-1:0] felem_t;
    typedef logic [F_NBITS:0]   fwide_t;

    // Quadratic round coefficients H(x) = c0 + c1*x + c2*x^2.
    typedef struct packed {
        felem_t c2;
        felem_t c1;
        felem_t c0;
    } coef_t;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_GATE,
        SEND,
        WAIT_TAU,
        PREP
    } seq_state_e;

    // Modular add of two reduced elements: one conditional subtract.
    function automatic felem_t modadd(input felem_t a, input felem_t b);
        fwide_t s;
        s = fwide_t'(a) + fwide_t'(b);
        if (s >= fwide_t'(F_Q)) begin
            s = s - fwide_t'(F_Q);
        end
        return s[F_NBITS-1:0];
    endfunction

    // Single-subtract reduction; inputs are assumed below 2*F_Q.
    function automatic felem_t reduce_once(input felem_t t);
        felem_t r;
        r = t;
        if (t >= F_Q) begin
            r = t - F_Q;
        end
        return r;
    endfunction

    // (1 - t) mod F_Q for a reduced t, widened so F_Q+1 never wraps.
    function automatic felem_t one_minus(input felem_t t);
        fwide_t w;
        felem_t r;
        w = (fwide_t'(F_Q) + fwide_t'(1)) - fwide_t'(t);
        if (t == '0) begin
            r = F_NBITS'(1);
        end else if (t == F_NBITS'(1)) begin
            r = '0;
        end else begin
            r = w[F_NBITS-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/prover_late_round_seq_if.sv
// Verifier-side channel: coefficients out, challenge tau back in.
interface prover_late_round_seq_if;
    import prover_late_seq_pkg::*;

    coef_t  coef_out;
    logic   coef_valid;
    logic   coef_ready;
    felem_t tau_in;
    logic   tau_valid;
    logic   tau_ready;

    modport master (
        output coef_out,
        output coef_valid,
        input  coef_ready,
        input  tau_in,
        input  tau_valid,
        output tau_ready
    );

    modport slave (
        input  coef_out,
        input  coef_valid,
        output coef_ready,
        output tau_in,
        output tau_valid,
        input  tau_ready
    );

endinterface

// File: rtl/field_one_minus_reg.sv
// Captures and reduces the verifier challenge, then registers tau and (1 - tau)
// for the next compute pass; both outputs hold until the next load.
module field_one_minus_reg
    import prover_late_seq_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   cap_en,
    input  logic   load_en,
    input  felem_t tau_in,
    output felem_t tau_out,
    output felem_t m_tau_p1_out
);

    felem_t tau_cap;

    always_ff @(posedge clk) begin
        if (rst) begin
            tau_cap      <= '0;
            tau_out      <= '0;
            m_tau_p1_out <= '0;
        end else begin
            if (cap_en) begin
                tau_cap <= reduce_once(tau_in);
            end
            if (load_en) begin
                tau_out      <= tau_cap;
                m_tau_p1_out <= one_minus(tau_cap);
            end
        end
    end

endmodule

// File: rtl/prover_late_round_seq.sv
// Late-round sum-check sequencer: one compute pass per round, coefficients to the
// verifier, challenge back. Optional round-sum check under PROVER_LATE_SUMCHK_EN.
module prover_late_round_seq
    import prover_late_seq_pkg::*;
#(
    parameter  int unsigned ninputs = 8,
    localparam int unsigned ninbits = $clog2(ninputs),
    localparam int unsigned nrounds = 2 * ninbits,
    localparam int unsigned RND_W   = $clog2(nrounds + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [RND_W-1:0]            round,
    output logic                        gate_en,
    output logic                        gate_restart,
    input  logic                        gate_ready_pulse,
    input  coef_t                       gate_c,
    output felem_t                      tau_out,
    output felem_t                      m_tau_p1_out,
    output felem_t                      sum_out,
    prover_late_round_seq_if.master     chan
);

    seq_state_e       state_q, state_d;
    logic [RND_W-1:0] round_d;
    logic             busy_d, done_d, gate_en_d, gate_restart_d;
    logic             coef_valid_d, tau_ready_d;
    logic             coef_hs, tau_hs, last_round, gate_latch, sum_ready_d;
    coef_t            coef_q;

    assign coef_hs    = chan.coef_valid & chan.coef_ready;
    assign tau_hs     = chan.tau_valid & chan.tau_ready;
    assign last_round = (round == RND_W'(nrounds - 1));
    assign gate_latch = (state_q == WAIT_GATE) & gate_ready_pulse;

`ifdef PROVER_LATE_SUMCHK_EN
    logic [1:0] sum_step_q;
    felem_t     sum_acc_q, sum_q;

    // Round sum 2*c0 + c1 + c2 folded over three cycles after the latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_step_q <= 2'd0;
            sum_acc_q  <= '0;
            sum_q      <= '0;
        end else if (gate_latch) begin
            sum_step_q <= 2'd1;
        end else begin
            case (sum_step_q)
                2'd1: begin
                    sum_acc_q  <= modadd(coef_q.c0, coef_q.c0);
                    sum_step_q <= 2'd2;
                end
                2'd2: begin
                    sum_acc_q  <= modadd(sum_acc_q, coef_q.c1);
                    sum_step_q <= 2'd3;
                end
                2'd3: begin
                    sum_q      <= modadd(sum_acc_q, coef_q.c2);
                    sum_step_q <= 2'd0;
                end
                default: ;
            endcase
        end
    end

    // Valid may only rise once the sum lands, so a ready verifier never races it.
    assign sum_ready_d = ~gate_latch & ((sum_step_q == 2'd0) | (sum_step_q == 2'd3));
    assign sum_out     = sum_q;
`else
    assign sum_ready_d = 1'b1;
    assign sum_out     = '0;
`endif

    always_comb begin
        state_d = state_q;
        round_d = round;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LAUNCH;
                    round_d = '0;
                end
            end
            LAUNCH:    state_d = WAIT_GATE;
            WAIT_GATE: if (gate_ready_pulse) state_d = SEND;
            SEND:      if (coef_hs) state_d = WAIT_TAU;
            WAIT_TAU: begin
                if (tau_hs) begin
                    state_d = PREP;
                    done_d  = last_round;
                end
            end
            PREP: begin
                if (last_round) begin
                    state_d = IDLE;
                end else begin
                    state_d = LAUNCH;
                    round_d = round + RND_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d         = (state_d != IDLE);
        gate_en_d      = (state_d == LAUNCH);
        gate_restart_d = gate_en_d & (round_d == '0);
        coef_valid_d   = (state_d == SEND) & sum_ready_d;
        tau_ready_d    = (state_d == WAIT_TAU);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            round           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            gate_en         <= 1'b0;
            gate_restart    <= 1'b0;
            chan.coef_valid <= 1'b0;
            chan.tau_ready  <= 1'b0;
        end else begin
            state_q         <= state_d;
            round           <= round_d;
            busy            <= busy_d;
            done            <= done_d;
            gate_en         <= gate_en_d;
            gate_restart    <= gate_restart_d;
            chan.coef_valid <= coef_valid_d;
            chan.tau_ready  <= tau_ready_d;
        end
    end

    // Coefficients are latched once per pass and held through SEND.
    always_ff @(posedge clk) begin
        if (rst) begin
            coef_q <= '0;
        end else if (gate_latch) begin
            coef_q <= gate_c;
        end
    end

    assign chan.coef_out = coef_q;

    field_one_minus_reg u_tau_reg (
        .clk          (clk),
        .rst          (rst),
        .cap_en       (tau_hs),
        .load_en      (state_q == PREP),
        .tau_in       (chan.tau_in),
        .tau_out      (tau_out),
        .m_tau_p1_out (m_tau_p1_out)
    );

endmodule

// File: tb/tb_prover_late_round_seq.sv
// Randomised bench for prover_late_round_seq (ninputs=4, four rounds) against a
// plain-arithmetic model of the field rules and the round protocol.
module tb_prover_late_round_seq;
    import prover_late_seq_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned RW = 3;
    localparam longint unsigned Q = 64'(F_Q);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, gate_en, gate_restart;
    logic [RW-1:0] round_o;
    logic          gate_ready_pulse;
    coef_t         gate_c;
    felem_t        tau_out, m_tau_p1_out, sum_out;

    prover_late_round_seq_if chan();

    prover_late_round_seq #(.ninputs(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .round            (round_o),
        .gate_en          (gate_en),
        .gate_restart     (gate_restart),
        .gate_ready_pulse (gate_ready_pulse),
        .gate_c           (gate_c),
        .tau_out          (tau_out),
        .m_tau_p1_out     (m_tau_p1_out),
        .sum_out          (sum_out),
        .chan             (chan)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_gate_en = 0;
    int n_done    = 0;

    logic [31:0] tau_tab [NR];
    int          stall_tab [NR];
    coef_t       c_tab [NR];

    always @(negedge clk) begin
        if (gate_en) n_gate_en++;
        if (done)    n_done++;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned red(input longint unsigned t);
        return t % Q;
    endfunction

    function automatic longint unsigned mtau(input longint unsigned t);
        return (Q + 1 - (t % Q)) % Q;
    endfunction

    function automatic coef_t rand_coef();
        coef_t c;
        c.c0 = $urandom % F_Q;
        c.c1 = $urandom % F_Q;
        c.c2 = $urandom % F_Q;
        return c;
    endfunction

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_to_launch", gate_en, 1);
        check_eq("start_busy", busy, 1);
    endtask

    task automatic run_round(input int r, input logic [31:0] tau, input int stall, input bit poke);
        int n;
        coef_t c;
        longint unsigned s;
        n = 0;
        while (!gate_en && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("launch_seen", gate_en, 1);
        check_eq("round_idx", round_o, r);
        check_eq("restart", gate_restart, (r == 0));
        @(negedge clk);
        check_eq("gate_en_pulse", gate_en, 0);
        if (poke) begin
            start = 1'b1;
            chan.tau_valid = 1'b1;
            chan.tau_in = $urandom;
            @(negedge clk);
            start = 1'b0;
            chan.tau_valid = 1'b0;
            check_eq("poke_round", round_o, r);
            check_eq("poke_tau_ready", chan.tau_ready, 0);
            check_eq("poke_gate_en", gate_en, 0);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        c = c_tab[r];
        gate_c = c;
        gate_ready_pulse = 1'b1;
        @(negedge clk);
        gate_ready_pulse = 1'b0;
        gate_c = rand_coef();
`ifdef PROVER_LATE_SUMCHK_EN
        n = 0;
        while (!chan.coef_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
`endif
        check_eq("coef_valid", chan.coef_valid, 1);
        check_eq("coef_out", chan.coef_out, c);
`ifdef PROVER_LATE_SUMCHK_EN
        s = 2 * 64'(c.c0) + 64'(c.c1) + 64'(c.c2);
        check_eq("sum_out", sum_out, s % Q);
`else
        s = 0;
        check_eq("sum_out_zero", sum_out, s);
`endif
        chan.coef_ready = 1'b0;
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            check_eq("stall_valid", chan.coef_valid, 1);
            check_eq("stall_coef", chan.coef_out, c);
            check_eq("stall_tau_ready", chan.tau_ready, 0);
        end
        chan.coef_ready = 1'b1;
        @(negedge clk);
        chan.coef_ready = 1'b0;
        check_eq("coef_drop", chan.coef_valid, 0);
        check_eq("tau_ready", chan.tau_ready, 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        chan.tau_in = tau;
        chan.tau_valid = 1'b1;
        @(negedge clk);
        chan.tau_valid = 1'b0;
        check_eq("tau_ready_drop", chan.tau_ready, 0);
        check_eq("done", done, (r == NR - 1));
        @(negedge clk);
        check_eq("tau_out", tau_out, red(64'(tau)));
        check_eq("m_tau_p1", m_tau_p1_out, mtau(64'(tau)));
        if (r < NR - 1) check_eq("relaunch", gate_en, 1);
        else            check_eq("busy_end", busy, 0);
    endtask

    task automatic run_layer(input bit poke);
        int g0, d0;
        g0 = n_gate_en;
        d0 = n_done;
        kick();
        for (int r = 0; r < NR; r++) begin
            run_round(r, tau_tab[r], stall_tab[r], poke && (r == 1));
        end
        repeat (3) @(negedge clk);
        check_eq("launch_count", n_gate_en - g0, NR);
        check_eq("done_count", n_done - d0, 1);
        check_eq("tau_hold", tau_out, red(64'(tau_tab[NR-1])));
        check_eq("m_hold", m_tau_p1_out, mtau(64'(tau_tab[NR-1])));
    endtask

    task automatic randomize_layer();
        for (int r = 0; r < NR; r++) begin
            tau_tab[r]   = $urandom;
            stall_tab[r] = $urandom_range(0, 3);
            c_tab[r]     = rand_coef();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, {busy, done, gate_en, gate_restart, chan.coef_valid, chan.tau_ready}, 0);
        check_eq({tag, "_round"}, round_o, 0);
        check_eq({tag, "_coef"}, chan.coef_out, 0);
        check_eq({tag, "_fields"}, {tau_out, m_tau_p1_out, sum_out}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, g0;
        rst = 1'b1;
        start = 1'b0;
        gate_ready_pulse = 1'b0;
        gate_c = '0;
        chan.coef_ready = 1'b0;
        chan.tau_in = '0;
        chan.tau_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Fixed taus 0,1,5,7 with a long coefficient stall in round 2.
        tau_tab[0] = 32'd0;
        tau_tab[1] = 32'd1;
        tau_tab[2] = 32'd5;
        tau_tab[3] = 32'd7;
        stall_tab[0] = 0;
        stall_tab[1] = 0;
        stall_tab[2] = 10;
        stall_tab[3] = 0;
        c_tab[0].c0 = 32'd1;
        c_tab[0].c1 = 32'd2;
        c_tab[0].c2 = 32'd3;
        c_tab[1].c0 = F_Q - 32'd1;
        c_tab[1].c1 = 32'd1;
        c_tab[1].c2 = 32'd0;
        c_tab[2] = rand_coef();
        c_tab[3] = rand_coef();
        run_layer(1'b1);

        // Unreduced challenges at the top of the input range.
        randomize_layer();
        tau_tab[0] = F_Q + 32'd3;
        tau_tab[3] = F_Q + 32'd4;
        run_layer(1'b0);

        // Reset while waiting for the round-1 compute pass.
        randomize_layer();
        d0 = n_done;
        kick();
        run_round(0, tau_tab[0], stall_tab[0], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        g0 = n_gate_en;
        repeat (5) @(negedge clk);
        check_eq("midrst_no_done", n_done - d0, 0);
        check_eq("midrst_no_launch", n_gate_en - g0, 0);

        for (int k = 0; k < 3; k++) begin
            randomize_layer();
            run_layer(1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
